// File: rtl/pc_fetch_ctrl.sv
// Program counter plus instruction-fetch controller. It issues one fetch at a time,
// holds the fetched instruction for execute, and redirects, halts or advances the PC.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_next_in,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [31:0]      pc_out,
    output logic [31:0]      pc_plus_four,
    output logic             misaligned_fault,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_t;

    state_t      state;
    logic        drop;
    logic [31:0] redirect_target;
    logic        next_aligned;

    assign redirect_target = redirect_pc & ~32'd3;
    assign next_aligned    = (pc_next_in[1:0] == 2'b00);

    assign imem_req     = (state == S_FETCH);
    assign imem_addr    = pc_out;
    assign pc_plus_four = pc_out + 32'd4;

    // NOTE: all state lives in this one clocked block and is assigned with <= only,
    // so every branch reads the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_FETCH;
            pc_out           <= RESET_PC;
            instr            <= 32'h0;
            instr_valid      <= 1'b0;
            misaligned_fault <= 1'b0;
            instret          <= '0;
            drop             <= 1'b0;
        end else if (redirect) begin
            state       <= S_FETCH;
            pc_out      <= redirect_target;
            instr_valid <= 1'b0;
            if (state == S_HALT) begin
                misaligned_fault <= 1'b0;
            end
            // A beat still owed by memory (or accepted right now) must be thrown away.
            unique case (state)
                S_FETCH: drop <= imem_ready | (drop & ~imem_rvalid);
                S_WAIT:  drop <= drop | ~imem_rvalid;
                default: drop <= drop & ~imem_rvalid;
            endcase
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (drop && imem_rvalid) begin
                        drop <= 1'b0;
                    end
                    if (imem_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop <= 1'b0;
                        end else begin
                            instr       <= imem_rdata;
                            instr_valid <= 1'b1;
                            state       <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        if (next_aligned) begin
                            pc_out  <= pc_next_in;
                            instret <= instret + CNT_W'(1);
                            state   <= S_FETCH;
                        end else begin
                            misaligned_fault <= 1'b1;
                            state            <= S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    // Only a redirect or reset leaves HALT.
                end
            endcase
        end
    end

endmodule
